// File: rtl/conv_pkg.sv
// Shared definitions for the CONV host-side responder.
//   DW / AW      : data word width (4.16 signed fixed point) and image/L0 address width
//   CSEL_*       : layer select encodings used on the csel bus
//   host_state_e : run sequencer states
package conv_pkg;

  localparam int DW = 20;
  localparam int AW = 12;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN,
    DONE
  } host_state_e;

endpackage

// File: rtl/conv_host_mem_if.sv
// Accelerator <-> host bus: ready/busy handshake, image read port and layer
// memory read/write port.
//   master : accelerator side (drives busy, iaddr, cwr/crd/csel and addresses)
//   slave  : host side (drives ready, idata, cdata_rd)
interface conv_host_mem_if
  import conv_pkg::*;
#(
  parameter int DW = conv_pkg::DW,
  parameter int AW = conv_pkg::AW
) ();

  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;

  modport master (
    input  ready, idata, cdata_rd,
    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, idata, cdata_rd,
    input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

endinterface

// File: rtl/conv_sp_ram.sv
// Single-write-port RAM with NRD asynchronous (zero-latency) read ports.
// Contents are not reset.
//   clk   : write clock
//   we    : write enable, commits wdata to mem[waddr] at posedge clk
//   raddr : NRD packed read addresses
//   rdata : NRD packed read data, combinational from raddr
module conv_sp_ram #(
  parameter int DW    = 20,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRD   = 1
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [DW-1:0]          wdata,
  input  logic [NRD-1:0][AW-1:0] raddr,
  output logic [NRD-1:0][DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NRD; i++) rdata[i] = mem[raddr[i]];
  end

endmodule

// File: rtl/conv_host_mem.sv
// Host-side responder for the CONV accelerator. Owns the image, layer-0 and
// layer-1 memories, sequences one run (load, ready/busy handshake, completion)
// and streams layer-1 out on a valid/ready port.
//   clk, reset          : clock, asynchronous active-high reset
//   ld_we/ld_addr/ld_data : image load port (IDLE only)
//   start               : single-cycle run request
//   acc                 : accelerator bus (ready/busy, image and layer access)
//   res_*               : layer-1 result stream, res_addr is the L1 index
//   done                : one-cycle pulse after the last result is accepted
//   err                 : sticky protocol error
module conv_host_mem
  import conv_pkg::*;
#(
  parameter int DW        = conv_pkg::DW,
  parameter int AW        = conv_pkg::AW,
  parameter int IMG_DEPTH = 4096,
  parameter int L0_DEPTH  = 4096,
  parameter int L1_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ld_we,
  input  logic [AW-1:0]                ld_addr,
  input  logic [DW-1:0]                ld_data,
  input  logic                         start,
  conv_host_mem_if.slave               acc,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(L1_DEPTH)-1:0]  res_addr,
  output logic [DW-1:0]                res_data,
  output logic                         done,
  output logic                         err
);

  localparam int L1_AW = $clog2(L1_DEPTH);
  localparam logic [L1_AW-1:0] LAST_IDX = L1_AW'(L1_DEPTH - 1);

  host_state_e      state_q, state_d;
  logic [L1_AW-1:0] cnt_q, cnt_d;
  logic             err_q;

  logic             in_idle, in_run, acc_ok, l1_addr_ok;
  logic             img_we, l0_we, l1_we, err_set;
  logic [DW-1:0]    l0_rd;
  logic [1:0][DW-1:0] l1_rd;

  assign in_idle    = (state_q == IDLE);
  assign in_run     = (state_q == RUN);
  assign acc_ok     = (state_q == RUN) || (state_q == ARM);
  assign l1_addr_ok = (acc.caddr_wr[AW-1:L1_AW] == '0);

  // Writes are committed only when the access is legal; an illegal access is
  // dropped and only raises err.
  assign img_we = ld_we && in_idle;
  assign l0_we  = acc.cwr && (acc.csel == CSEL_L0) && in_run;
  assign l1_we  = acc.cwr && (acc.csel == CSEL_L1) && l1_addr_ok && in_run;

  assign err_set = (acc.cwr && (acc.csel != CSEL_L0) && (acc.csel != CSEL_L1))
                || (acc.cwr && (acc.csel == CSEL_L1) && !l1_addr_ok)
                || ((acc.cwr || acc.crd) && !acc_ok)
                || (ld_we && !in_idle);

  conv_sp_ram #(.DW(DW), .DEPTH(IMG_DEPTH), .AW(AW), .NRD(1)) u_img (
    .clk   (clk),
    .we    (img_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (acc.iaddr),
    .rdata (acc.idata)
  );

  conv_sp_ram #(.DW(DW), .DEPTH(L0_DEPTH), .AW(AW), .NRD(1)) u_l0 (
    .clk   (clk),
    .we    (l0_we),
    .waddr (acc.caddr_wr),
    .wdata (acc.cdata_wr),
    .raddr (acc.caddr_rd),
    .rdata (l0_rd)
  );

  // Port 0 serves the accelerator, port 1 feeds the result stream.
  conv_sp_ram #(.DW(DW), .DEPTH(L1_DEPTH), .AW(L1_AW), .NRD(2)) u_l1 (
    .clk   (clk),
    .we    (l1_we),
    .waddr (acc.caddr_wr[L1_AW-1:0]),
    .wdata (acc.cdata_wr),
    .raddr ({cnt_q, acc.caddr_rd[L1_AW-1:0]}),
    .rdata (l1_rd)
  );

  always_comb begin
    acc.cdata_rd = '0;
    if (acc.csel == CSEL_L0)      acc.cdata_rd = l0_rd;
    else if (acc.csel == CSEL_L1) acc.cdata_rd = l1_rd[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ARM;
      ARM:   if (acc.busy) state_d = RUN;
      RUN: begin
        if (!acc.busy) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (cnt_q == LAST_IDX) state_d = DONE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc.ready = (state_q == ARM);
  assign res_valid = (state_q == DRAIN);
  assign res_addr  = cnt_q;
  assign res_data  = l1_rd[1];
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_conv_host_mem.sv
module tb_conv_host_mem;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_we;
  logic [11:0] ld_addr;
  logic [19:0] ld_data;
  logic        start;
  logic        res_valid;
  logic        res_ready;
  logic [9:0]  res_addr;
  logic [19:0] res_data;
  logic        done;
  logic        err;

  conv_host_mem_if bus ();

  conv_host_mem dut (
    .clk       (clk),
    .reset     (reset),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .acc       (bus),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [19:0] data;
  } exp_t;

  exp_t        q[$];
  logic [19:0] l1_m [1024];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected stream: every L1 word in index order.
  task automatic push_expected();
    exp_t e;
    q.delete();
    for (int i = 0; i < 1024; i++) begin
      e.addr = 10'(i);
      e.data = l1_m[i];
      q.push_back(e);
    end
  endtask

  // Called at a negedge while in DRAIN. Pops one expected word per accepted
  // beat; stops early (without accepting) when res_addr reaches stop_at.
  task automatic drain(input int stop_at, output bit hit_stop);
    int cyc = 0;
    int k   = 0;
    bit rdy;
    hit_stop = 1'b0;
    while (q.size() > 0 && cyc < 8000) begin
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_addr",  32'(res_addr),  32'(q[0].addr));
      check("res_data",  32'(res_data),  32'(q[0].data));
      if (int'(q[0].addr) == stop_at) begin
        res_ready = 1'b0;
        hit_stop  = 1'b1;
        return;
      end
      if (k == 1 || k == 2)      rdy = 1'b0;
      else if (k == 0 || k == 3) rdy = 1'b1;
      else                       rdy = ($urandom_range(7) != 0);
      k++;
      res_ready = rdy;
      if (rdy) void'(q.pop_front());
      @(negedge clk);
      cyc++;
    end
    res_ready = 1'b0;
    check("drain_left", 32'(q.size()), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("valid_after_last", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("done_once", 32'(done), 32'd0);
    check("idle_ready", 32'(bus.ready), 32'd0);
    check("idle_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    bit          hit;
    logic [9:0]  iv;
    logic [19:0] fv;

    reset = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; res_ready = 1'b0;
    bus.busy = 1'b0; bus.iaddr = '0; bus.cwr = 1'b0; bus.caddr_wr = '0;
    bus.cdata_wr = '0; bus.crd = 1'b0; bus.caddr_rd = '0; bus.csel = CSEL_NONE;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_addr",  32'(res_addr),  32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Image load; last write coincides with start.
    ld_we = 1'b1; ld_addr = 12'd0; ld_data = 20'h0A000;
    @(negedge clk);
    ld_addr = 12'd4095; ld_data = 20'h00123; start = 1'b1;
    @(negedge clk);
    ld_we = 1'b0; start = 1'b0;
    check("arm_ready1", 32'(bus.ready), 32'd1);
    bus.iaddr = 12'd0; #1;
    check("idata_0", 32'(bus.idata), 32'h0A000);
    bus.iaddr = 12'd4095; #1;
    check("idata_4095", 32'(bus.idata), 32'h00123);
    @(negedge clk);
    check("arm_ready2", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check("arm_ready3", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check("arm_ready4", 32'(bus.ready), 32'd1);
    bus.busy = 1'b1;
    @(negedge clk);
    check("run_ready", 32'(bus.ready), 32'd0);
    check("run_valid", 32'(res_valid), 32'd0);

    // L0 write then read back.
    bus.cwr = 1'b1; bus.csel = CSEL_L0; bus.caddr_wr = 12'd70; bus.cdata_wr = 20'h01310;
    @(negedge clk);
    bus.cwr = 1'b0; bus.crd = 1'b1; bus.caddr_rd = 12'd70; #1;
    check("l0_rd70", 32'(bus.cdata_rd), 32'h01310);
    bus.csel = 3'b010; #1;
    check("rd_nosel", 32'(bus.cdata_rd), 32'd0);
    bus.crd = 1'b0;

    // Fill all of L1 so the drain has defined data.
    for (int i = 0; i < 1024; i++) begin
      iv = i[9:0];
      fv = {iv, ~iv};
      bus.cwr = 1'b1; bus.csel = CSEL_L1; bus.caddr_wr = {2'b00, iv}; bus.cdata_wr = fv;
      l1_m[i] = fv;
      @(negedge clk);
    end
    bus.cdata_wr = 20'h05A5A; bus.caddr_wr = 12'd5; l1_m[5] = 20'h05A5A;
    @(negedge clk);
    bus.cwr = 1'b0; bus.crd = 1'b1; bus.caddr_rd = 12'd5; #1;
    check("l1_rd5", 32'(bus.cdata_rd), 32'h05A5A);
    bus.caddr_rd = 12'd1023; #1;
    check("l1_rd1023", 32'(bus.cdata_rd), 32'(l1_m[1023]));
    check("err_clean", 32'(err), 32'd0);

    // Out-of-range L1 write: dropped, err set.
    bus.crd = 1'b0; bus.cwr = 1'b1; bus.caddr_wr = 12'h405; bus.cdata_wr = 20'hFFFFF;
    @(negedge clk);
    bus.cwr = 1'b0; bus.crd = 1'b1; bus.caddr_rd = 12'd5; #1;
    check("err_l1_range", 32'(err), 32'd1);
    check("l1_rd5_kept", 32'(bus.cdata_rd), 32'h05A5A);
    bus.crd = 1'b0; bus.csel = CSEL_NONE;

    // Drain, interrupted by reset at index 300.
    bus.busy = 1'b0;
    push_expected();
    @(negedge clk);
    drain(300, hit);
    check("reached_300", 32'(hit), 32'd1);
    q.delete();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.ready), 32'd0);
    check("mid_rst_err",   32'(err),       32'd0);
    check("mid_rst_addr",  32'(res_addr),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Re-run; busy drops in the first RUN cycle; L1 must be intact.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("arm2_ready", 32'(bus.ready), 32'd1);
    bus.busy = 1'b1;
    @(negedge clk);
    check("run2_ready", 32'(bus.ready), 32'd0);
    bus.busy = 1'b0;
    push_expected();
    @(negedge clk);
    drain(1024, hit);

    // Protocol violations in RUN.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.busy = 1'b1;
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 12'd0; ld_data = 20'hFFFFF; start = 1'b1;
    @(negedge clk);
    ld_we = 1'b0; start = 1'b0;
    check("err_ld_run", 32'(err), 32'd1);
    check("start_ignored", 32'(bus.ready), 32'd0);
    bus.cwr = 1'b1; bus.csel = 3'b010; bus.caddr_wr = 12'd70; bus.cdata_wr = 20'h00000;
    @(negedge clk);
    bus.cwr = 1'b0; bus.csel = CSEL_L0; bus.caddr_rd = 12'd70; bus.iaddr = 12'd0; #1;
    check("l0_kept", 32'(bus.cdata_rd), 32'h01310);
    check("img_kept", 32'(bus.idata), 32'h0A000);
    @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    check("still_run", 32'(res_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_host_mem.md
Name: conv_host_mem

Overview:
Host-side responder for the CONV accelerator. It owns the 64x64 image memory and answers the accelerator's iaddr/idata reads. It also owns the layer-0 memory (4096 words) and layer-1 memory (1024 words) and answers the cwr/crd/csel accesses. It sequences one run (image load, ready/busy handshake, completion detect) and streams the 32x32 max-pooled result out on a valid/ready port.

Parameters:
DW, 20, data word width (4.16 signed fixed point)
AW, 12, address width for image and layer-0 memories
IMG_DEPTH, 4096, image memory words
L0_DEPTH, 4096, layer-0 memory words
L1_DEPTH, 1024, layer-1 memory words

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
ld_we  in  1  image load write strobe
ld_addr  in  12  image load address
ld_data  in  20  image load data
start  in  1  single-cycle request to begin a run
ready  out  1  start request to accelerator
busy  in  1  accelerator busy
iaddr  in  12  image read address
idata  out  20  image read data
cwr  in  1  layer write enable
caddr_wr  in  12  layer write address
cdata_wr  in  20  layer write data
crd  in  1  layer read enable
caddr_rd  in  12  layer read address
cdata_rd  out  20  layer read data
csel  in  3  layer select: 001 = L0, 011 = L1, others = none
res_valid  out  1  result word valid
res_ready  in  1  result sink ready
res_addr  out  10  L1 index of res_data
res_data  out  20  L1 word
done  out  1  one-cycle pulse after the last result is accepted
err  out  1  sticky protocol error, cleared only by reset

Behaviour:
- Reset values: ready=0, res_valid=0, res_addr=0, done=0, err=0, state=IDLE. Memory arrays are not reset; contents survive reset.
- Reset mid-operation returns the block to IDLE immediately, with the same output values.
- Reads are asynchronous with zero latency:
  - idata = IMG[iaddr] in the same cycle.
  - cdata_rd = L0[caddr_rd] when csel=001, L1[caddr_rd[9:0]] when csel=011, otherwise 0. crd is a qualifier only.
- Writes commit at posedge clk when cwr=1:
  - csel=001 writes L0[caddr_wr].
  - csel=011 writes L1[caddr_wr[9:0]].
  - Either case is only accepted in RUN.
- err sets on any of:
  - cwr=1 with csel not in {001, 011};
  - csel=011 with caddr_wr[11:10] != 0;
  - cwr or crd asserted outside RUN/ARM;
  - ld_we asserted outside IDLE.
  The offending access is dropped.
- Image load: ld_we in IDLE writes IMG[ld_addr] at posedge. When ld_we and start coincide, the write commits and the run starts.
- State IDLE: start=1 -> ARM. start is ignored in all other states.
- State ARM: ready=1. When busy=1 is sampled, go to RUN and drop ready in the same edge. ready is therefore high for at least one cycle and includes the cycle busy is first seen.
- State RUN: ready=0, serving memories. When busy=0 is sampled, go to DRAIN with the drain counter set to 0. busy deasserting in the first RUN cycle is legal.
- State DRAIN:
  - res_valid=1, res_addr=counter, res_data=L1[counter].
  - On res_valid&res_ready the counter increments.
  - res_data/res_addr stay stable while res_ready=0.
  - Acceptance of counter=1023 -> DONE.
- State DONE: done=1 for one cycle, then IDLE.
- Counter is 10 bits; no wrap is reachable, since exit occurs at 1023.
- Throughput: one word per cycle with res_ready held high, so the drain takes 1024 cycles.

Decomposition:
- Shared package conv_pkg:
  - CSEL_NONE=3'b000, CSEL_L0=3'b001, CSEL_L1=3'b011;
  - DW/AW constants;
  - host state enum {IDLE, ARM, RUN, DRAIN, DONE}.
- One sub-module, conv_sp_ram: parameterised single-write, asynchronous-read RAM. It is instantiated three times (IMG, L0, L1).

Test Plan:
- Load IMG[0]=20'h0A000, IMG[4095]=20'h00123, pulse start, accelerator holds iaddr=0 then 4095 -> idata 20'h0A000 then 20'h00123 in the same cycle.
- start, busy rises 3 cycles later -> ready high for exactly 4 cycles, drops the cycle after busy sampled; state RUN.
- In RUN: cwr=1, csel=001, caddr_wr=12'd70, cdata_wr=20'h01310; next cycle crd=1, caddr_rd=70 -> cdata_rd=20'h01310. Repeat with csel=011, caddr_wr=12'd5 -> L1[5] readable; caddr_wr=12'h405 with csel=011 -> err=1, L1 unchanged.
- busy falls, res_ready toggles 1,0,0,1 -> res_addr 0,1,1,1 then 2; res_data matches L1 and is stable while stalled; after 1024 acceptances done pulses once, state IDLE.
- Reset asserted in DRAIN at res_addr=300 -> res_valid=0, ready=0, err=0 immediately; new start re-runs and L1 contents are still intact.
- ld_we during RUN, and cwr=1 with csel=010 -> err=1 sticky and no memory changes; start during RUN ignored.
